// File: rtl/cfg_bridge.sv
// cfg_bridge: Wishbone register window driving N accelerator weight/bias memories.
// A command register launches single-word store/load operations on the port selected
// by the top bits of ADDR; status reports busy/done/error; optional address auto-increment.
module cfg_bridge #(
  parameter int unsigned NUM_PORTS          = 3,
  parameter int unsigned DATA_WORDS         = 4,
  parameter int unsigned ADDR_BW            = 12,
  parameter int unsigned RD_LATENCY         = 1,
  parameter logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000,
  localparam int unsigned PSEL_BW           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int unsigned VW                = 32 * DATA_WORDS,
  localparam int unsigned LA_BW             = ADDR_BW - PSEL_BW
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  output logic [LA_BW-1:0]          mem_addr_o,
  output logic [VW-1:0]             mem_wr_data_o,
  output logic [NUM_PORTS-1:0]      mem_wr_en_o,
  output logic [NUM_PORTS-1:0]      mem_rd_en_o,
  input  logic [NUM_PORTS*VW-1:0]   mem_rd_data_i
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StWait} state_e;

  state_e                       state_q, state_d;
  logic [ADDR_BW-1:0]           addr_q, addr_d;
  logic [DATA_WORDS-1:0][31:0]  data_q, data_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
  logic                         autoinc_q, autoinc_d;
  logic                         ack_q, ack_d;
  logic [31:0]                  rdat_q, rdat_d;
  logic [2:0]                   cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]         wr_en_q, wr_en_d;
  logic [NUM_PORTS-1:0]         rd_en_q, rd_en_d;

  logic [31:0]        offset;
  logic [31:0]        data_off;
  logic [31:0]        rdata;
  logic [31:0]        status;
  logic [PSEL_BW-1:0] psel;
  logic               psel_ok;
  logic               busy;
  logic               accept;
  logic [1:0]         cmd;

  assign offset   = wbs_adr_i - WISHBONE_BASE_ADDR;
  assign data_off = offset - 32'h10;
  assign psel     = addr_q[ADDR_BW-1 -: PSEL_BW];
  assign psel_ok  = 32'(psel) < NUM_PORTS;
  assign busy     = (state_q != StIdle);
  assign accept   = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign status   = {29'd0, err_q, done_q, busy};
  assign cmd      = wbs_dat_i[1:0];

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  // Register read mux; unmapped and write-only offsets read as zero.
  always_comb begin
    rdata = '0;
    if (offset == 32'h0) begin
      rdata = 32'(addr_q);
    end else if (offset == 32'h8) begin
      rdata = status;
    end
    for (int k = 0; k < DATA_WORDS; k++) begin
      if (data_off == 32'(4 * k)) rdata = data_q[k];
    end
  end

  // Wishbone register writes, command launch and command FSM next state.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = done_q;
    err_d     = err_q;
    autoinc_d = autoinc_q;
    cnt_d     = cnt_q;
    rdat_d    = rdat_q;
    ack_d     = 1'b0;
    wr_en_d   = '0;
    rd_en_d   = '0;

    if (accept) begin
      ack_d  = 1'b1;
      rdat_d = rdata;
      if (wbs_we_i) begin
        if (offset == 32'h0) begin
          // ADDR must stay stable while a command uses it.
          if (busy) err_d = 1'b1;
          else      addr_d = ADDR_BW'(merge_lanes(32'(addr_q), wbs_dat_i, wbs_sel_i));
        end else if (offset == 32'h4) begin
          if (busy) begin
            err_d = 1'b1;
          end else begin
            done_d = 1'b0;
            err_d  = 1'b0;
            if (cmd == 2'b11 || !psel_ok) begin
              err_d  = 1'b1;
              done_d = 1'b1;
            end else if (cmd == 2'b00) begin
              done_d = 1'b1;
            end else begin
              autoinc_d = wbs_dat_i[2];
              if (cmd == 2'b01) begin
                state_d = StWrite;
                wr_en_d = NUM_PORTS'(1) << psel;
              end else begin
                state_d = StRead;
                rd_en_d = NUM_PORTS'(1) << psel;
              end
            end
          end
        end
        for (int k = 0; k < DATA_WORDS; k++) begin
          if (data_off == 32'(4 * k)) data_d[k] = merge_lanes(data_q[k], wbs_dat_i, wbs_sel_i);
        end
      end
    end

    // FSM evaluated after bus writes so a load capture wins over a same-edge DATA write.
    unique case (state_q)
      StIdle: ;
      StWrite: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (autoinc_q) addr_d = addr_q + 1'b1;
      end
      StRead: begin
        state_d = StWait;
        cnt_d   = 3'(RD_LATENCY - 1);
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          for (int k = 0; k < DATA_WORDS; k++) begin
            data_d[k] = mem_rd_data_i[32'(psel) * VW + 32 * k +: 32];
          end
          state_d = StIdle;
          done_d  = 1'b1;
          if (autoinc_q) addr_d = addr_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any command in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      autoinc_q <= 1'b0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      rdat_q    <= '0;
      wr_en_q   <= '0;
      rd_en_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      autoinc_q <= autoinc_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      rdat_q    <= rdat_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = rdat_q;
  assign mem_addr_o    = addr_q[LA_BW-1:0];
  assign mem_wr_data_o = data_q;
  assign mem_wr_en_o   = wr_en_q;
  assign mem_rd_en_o   = rd_en_q;

endmodule

// File: tb/tb_cfg_bridge.sv
// Directed bench for cfg_bridge: 3 ports, 4 data words, 12-bit ADDR, read latency 3.
module tb_cfg_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stb = 1'b0;
  logic         cyc = 1'b0;
  logic         we = 1'b0;
  logic [3:0]   sel = 4'h0;
  logic [31:0]  adr = '0;
  logic [31:0]  dat = '0;
  logic         ack;
  logic [31:0]  dato;
  logic [9:0]   mem_addr;
  logic [127:0] wr_data;
  logic [2:0]   wr_en;
  logic [2:0]   rd_en;
  logic [383:0] rd_data;
  logic [2:0]   rd_pipe0, rd_pipe1, rd_pipe2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cfg_bridge #(
    .NUM_PORTS  (3),
    .DATA_WORDS (4),
    .ADDR_BW    (12),
    .RD_LATENCY (3),
    .WISHBONE_BASE_ADDR (BASE)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (dat),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (dato),
    .mem_addr_o    (mem_addr),
    .mem_wr_data_o (wr_data),
    .mem_wr_en_o   (wr_en),
    .mem_rd_en_o   (rd_en),
    .mem_rd_data_i (rd_data)
  );

  // Memory model: data valid only in the cycle RD_LATENCY edges after rd_en is sampled.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pipe0 <= '0;
      rd_pipe1 <= '0;
      rd_pipe2 <= '0;
    end else begin
      rd_pipe0 <= rd_en;
      rd_pipe1 <= rd_pipe0;
      rd_pipe2 <= rd_pipe1;
    end
  end

  function automatic logic [31:0] pattern(input int p, input int k);
    if (p == 2) return 32'hA5A5_A5A5 + 32'h0101_0101 * 32'(k);
    return 32'h1000_0000 * 32'(p) + 32'(k);
  endfunction

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        rd_data[p*128 + 32*k +: 32] = rd_pipe2[p] ? pattern(p, k) : 32'hDEAD_BEEF;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  task automatic wb_cycle(input logic w, input logic [31:0] off, input logic [31:0] wd,
                          input logic [3:0] s, output logic [31:0] rd);
    logic got = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = w; adr = BASE + off; dat = wd; sel = s;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    rd = dato;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL wb_ack_timeout off=%h: ack=0 after 10 cycles, required 1", off);
    end
  endtask

  task automatic wb_write(input logic [31:0] off, input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] unused;
    wb_cycle(1'b1, off, wd, s, unused);
  endtask

  task automatic wb_read(input logic [31:0] off, output logic [31:0] rd);
    wb_cycle(1'b0, off, 32'h0, 4'hF, rd);
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({ack, dato, wr_en, rd_en, mem_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got ack=%b dat=%h wr=%b rd=%b addr=%h, required all 0",
               ack, dato, wr_en, rd_en, mem_addr);
    end
    vectors++;
    if (wr_data !== '0) begin
      miscompares++; $display("FAIL reset_wr_data got %h required 0", wr_data);
    end
    @(negedge clk); rst = 1'b0;
    wb_read(32'h8, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_status got %h required 0", rd); end
    wb_read(32'h0, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h required 0", rd); end
  endtask

  task automatic test_store;
    logic [31:0]  rd;
    logic [127:0] exp_vec = {32'h44, 32'h33, 32'h22, 32'h11};
    wb_write(32'h0, 32'h105, 4'hF);
    wb_write(32'h10, 32'h11, 4'hF);
    wb_write(32'h14, 32'h22, 4'hF);
    wb_write(32'h18, 32'h33, 4'hF);
    wb_write(32'h1C, 32'h44, 4'hF);
    wb_write(32'h4, 32'h1, 4'hF);
    vectors++;
    if (wr_en !== 3'b001 || rd_en !== 3'b000) begin
      miscompares++; $display("FAIL store_strobe got wr=%b rd=%b required wr=001 rd=000", wr_en, rd_en);
    end
    vectors++;
    if (mem_addr !== 10'h105) begin
      miscompares++; $display("FAIL store_addr got %h required 105", mem_addr);
    end
    vectors++;
    if (wr_data !== exp_vec) begin
      miscompares++; $display("FAIL store_wr_data got %h required %h", wr_data, exp_vec);
    end
    @(posedge clk); #1;
    vectors++;
    if (wr_en !== 3'b000) begin
      miscompares++; $display("FAIL store_strobe_len got wr=%b required 000", wr_en);
    end
    wb_read(32'h8, rd);
    vectors++;
    if (rd !== 32'h2) begin miscompares++; $display("FAIL store_status got %h required 2", rd); end
    wb_read(32'h0, rd);
    vectors++;
    if (rd !== 32'h105) begin miscompares++; $display("FAIL store_no_inc got %h required 105", rd); end
  endtask

  task automatic test_load_latency;
    logic [31:0] rd;
    logic [31:0] exp_st [3] = '{32'h1, 32'h1, 32'h2};
    wb_write(32'h0, 32'h800, 4'hF);
    wb_write(32'h4, 32'h2, 4'hF);
    vectors++;
    if (rd_en !== 3'b100 || wr_en !== 3'b000 || mem_addr !== 10'h000) begin
      miscompares++;
      $display("FAIL load_strobe got rd=%b wr=%b addr=%h required rd=100 wr=000 addr=000",
               rd_en, wr_en, mem_addr);
    end
    @(posedge clk); #1;
    vectors++;
    if (rd_en !== 3'b000) begin miscompares++; $display("FAIL load_strobe_len got %b required 000", rd_en); end
    // Status reads sample at E2, E4, E6; capture happens at E4.
    for (int i = 0; i < 3; i++) begin
      wb_read(32'h8, rd);
      vectors++;
      if (rd !== exp_st[i]) begin
        miscompares++; $display("FAIL load_status[%0d] got %h required %h", i, rd, exp_st[i]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      wb_read(32'h10 + 32'(4 * k), rd);
      vectors++;
      if (rd !== pattern(2, k)) begin
        miscompares++; $display("FAIL load_data[%0d] got %h required %h", k, rd, pattern(2, k));
      end
    end
  endtask

  task automatic test_autoinc;
    logic [31:0] rd;
    wb_write(32'h0, 32'h3FF, 4'hF);
    wb_write(32'h4, 32'h5, 4'hF);
    vectors++;
    if (wr_en !== 3'b001 || mem_addr !== 10'h3FF) begin
      miscompares++; $display("FAIL burst_first got wr=%b addr=%h required 001/3ff", wr_en, mem_addr);
    end
    wb_read(32'h0, rd);
    vectors++;
    if (rd !== 32'h400) begin miscompares++; $display("FAIL burst_addr1 got %h required 400", rd); end
    wb_write(32'h4, 32'h5, 4'hF);
    vectors++;
    if (wr_en !== 3'b010 || mem_addr !== 10'h000) begin
      miscompares++; $display("FAIL burst_second got wr=%b addr=%h required 010/000", wr_en, mem_addr);
    end
    wb_read(32'h0, rd);
    vectors++;
    if (rd !== 32'h401) begin miscompares++; $display("FAIL burst_addr2 got %h required 401", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd;
    wb_write(32'h0, 32'hC00, 4'hF);
    wb_write(32'h4, 32'h1, 4'hF);
    vectors++;
    if (wr_en !== 3'b000 || rd_en !== 3'b000) begin
      miscompares++; $display("FAIL err_port_strobe got wr=%b rd=%b required 000/000", wr_en, rd_en);
    end
    wb_read(32'h8, rd);
    vectors++;
    if (rd !== 32'h6) begin miscompares++; $display("FAIL err_port_status got %h required 6", rd); end
    wb_write(32'h0, 32'h000, 4'hF);
    wb_write(32'h4, 32'h3, 4'hF);
    vectors++;
    if (wr_en !== 3'b000 || rd_en !== 3'b000) begin
      miscompares++; $display("FAIL err_cmd_strobe got wr=%b rd=%b required 000/000", wr_en, rd_en);
    end
    wb_read(32'h8, rd);
    vectors++;
    if (rd !== 32'h6) begin miscompares++; $display("FAIL err_cmd_status got %h required 6", rd); end
    wb_write(32'h4, 32'h0, 4'hF);
    wb_read(32'h8, rd);
    vectors++;
    if (rd !== 32'h2) begin miscompares++; $display("FAIL nop_clears_err got %h required 2", rd); end
  endtask

  task automatic test_busy_error;
    logic [31:0] rd;
    wb_write(32'h10, 32'h0, 4'hF);
    wb_write(32'h0, 32'h800, 4'hF);
    wb_write(32'h4, 32'h2, 4'hF);
    wb_write(32'h4, 32'h1, 4'hF);  // lands while the load is waiting
    vectors++;
    if (wr_en !== 3'b000) begin miscompares++; $display("FAIL busy_ctrl_strobe got wr=%b required 000", wr_en); end
    wb_write(32'h0, 32'h000, 4'hF);  // also while busy
    wb_read(32'h8, rd);
    vectors++;
    if (rd !== 32'h6) begin miscompares++; $display("FAIL busy_status got %h required 6", rd); end
    wb_read(32'h0, rd);
    vectors++;
    if (rd !== 32'h800) begin miscompares++; $display("FAIL busy_addr_kept got %h required 800", rd); end
    wb_read(32'h10, rd);
    vectors++;
    if (rd !== 32'hA5A5_A5A5) begin
      miscompares++; $display("FAIL busy_load_done got %h required a5a5a5a5", rd);
    end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd;
    wb_write(32'h10, 32'hFFFF_FFFF, 4'hF);
    wb_write(32'h10, 32'h1234_5678, 4'b0101);
    wb_read(32'h10, rd);
    vectors++;
    if (rd !== 32'hFF34_FF78) begin miscompares++; $display("FAIL byte_lane_data got %h required ff34ff78", rd); end
    wb_write(32'h0, 32'h0, 4'hF);
    wb_write(32'h0, 32'h0000_ABCD, 4'b0001);
    wb_read(32'h0, rd);
    vectors++;
    if (rd !== 32'hCD) begin miscompares++; $display("FAIL byte_lane_addr got %h required cd", rd); end
    wb_write(32'h40, 32'hCAFE_F00D, 4'hF);
    wb_read(32'h40, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL unmapped_read got %h required 0", rd); end
    wb_read(32'h4, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL ctrl_read got %h required 0", rd); end
  endtask

  task automatic test_reset_mid_load;
    logic [31:0] rd;
    logic        seen = 1'b0;
    wb_write(32'h14, 32'h55, 4'hF);
    wb_write(32'h0, 32'h800, 4'hF);
    wb_write(32'h4, 32'h2, 4'hF);
    vectors++;
    if (rd_en !== 3'b100) begin miscompares++; $display("FAIL rst_load_start got rd=%b required 100", rd_en); end
    rst = 1'b1;
    #1;
    vectors++;
    if ({ack, dato, wr_en, rd_en} !== '0) begin
      miscompares++;
      $display("FAIL rst_async got ack=%b dat=%h wr=%b rd=%b required all 0", ack, dato, wr_en, rd_en);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rd_en !== 3'b000 || wr_en !== 3'b000) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL rst_no_strobe got strobe after reset, required none"); end
    wb_read(32'h8, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL rst_status got %h required 0", rd); end
    wb_read(32'h14, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL rst_data1 got %h required 0", rd); end
    wb_read(32'h10, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL rst_data0 got %h required 0", rd); end
    wb_read(32'h0, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %h required 0", rd); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_latency();
    test_autoinc();
    test_errors();
    test_busy_error();
    test_byte_lanes();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
